// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder feeding one full-adder cell, LSB first; optional ovf via SERIAL_ADDER_OVF_EN
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              fa_a;
    logic              fa_b;
    logic              fa_s;
    logic              fa_co;
    logic              accept;

    // The single full-adder cell sees one bit pair per ADD cycle.
    assign fa_a  = a_sh[0];
    assign fa_b  = b_sh[0];
    assign fa_s  = fa_a ^ fa_b ^ carry;
    assign fa_co = (fa_a & fa_b) | (fa_a & carry) | (fa_b & carry);

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == S_IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_ADD) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            sum   <= {fa_s, sum[WIDTH-1:1]};
            carry <= fa_co;
            // Counter parks at WIDTH-1 on the final step instead of wrapping.
            if (last) begin
                cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= carry ^ fa_co;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8), directed table plus random model
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf_w;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf_w),
`endif
        .busy      (busy)
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake is stable across the edge, so sample it mid-cycle.
    always @(negedge clk) if (in_valid && in_ready && !rst) acc_q.push_back(cyc);

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int bp,
                         output logic [W-1:0] s, output logic co, output logic ov, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        repeat (bp) tick();
        s = sum; co = cout; ov = ovf_w;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Reference: plain integer addition, signed range test for overflow.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int u;
        u = int'(a) + int'(b) + int'(c);
        return u[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int sv;
        sv = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (sv > 127) || (sv < -128);
    endfunction

    vec_t         vecs[8];
    logic [W-1:0] r_s;
    logic         r_co;
    logic         r_ov;
    logic [W:0]   e;
    int           lat;
    int           n;
    logic [W-1:0] held;
    logic         held_co;

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf_w, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, 0, r_s, r_co, r_ov, lat);
            chk($sformatf("vec%0d_latency", i), lat, W);
            chk($sformatf("vec%0d_sum", i), r_s, vecs[i].s);
            chk($sformatf("vec%0d_cout", i), r_co, vecs[i].co);
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("vec%0d_ovf", i), r_ov, vecs[i].ov);
`endif
            chk($sformatf("vec%0d_in_ready_after", i), in_ready, 1);
        end

        // Ignored in_valid during ADD, then backpressure in DONE.
        op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        tick();
        op_a = 8'hAA; op_b = 8'h33; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("add_in_ready_low", in_ready, 0);
            chk("add_busy", busy, 1);
            tick();
        end
        in_valid = 1'b0;
        lat = 3;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp_latency", lat, W);
        chk("bp_sum", sum, 8'h10);
        chk("bp_cout", cout, 0);
        held = sum; held_co = cout;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_sum_stable", sum, held);
            chk("bp_cout_stable", cout, held_co);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_next", in_ready, 1);
        chk("bp_out_valid_drop", out_valid, 0);

        // Reset three cycles into ADD.
        do_op(8'hC3, 8'h5A, 1'b1, 0, r_s, r_co, r_ov, lat);
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        tick();
        rst = 1'b0;
        tick();
        do_op(8'h55, 8'hAA, 1'b0, 0, r_s, r_co, r_ov, lat);
        chk("after_rst_latency", lat, W);
        chk("after_rst_sum", r_s, 8'hFF);
        chk("after_rst_cout", r_co, 0);

        // Back-to-back with both handshakes held high.
        acc_q.delete();
        op_a = 8'h21; op_b = 8'h43; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (acc_q.size() < 2 && n < 60) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (acc_q.size() >= 2) begin
            chk("b2b_interval", acc_q[1] - acc_q[0], W + 2);
        end else begin
            chk("b2b_accepts", acc_q.size(), 2);
        end
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        chk("b2b_sum", sum, 8'h65);
        tick();
        out_ready = 1'b0;
        chk("b2b_idle", in_ready, 1);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            do_op(a, b, c, int'($urandom_range(0, 2)), r_s, r_co, r_ov, lat);
            e = ref_add(a, b, c);
            chk("rnd_result", {r_co, r_s}, e);
            chk("rnd_latency", lat, W);
`ifdef SERIAL_ADDER_OVF_EN
            chk("rnd_ovf", r_ov, ref_ovf(a, b, c));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
